// File: rtl/fb_scan_reader.sv
// rtl/fb_scan_reader.sv - frame-buffer scan reader streaming RAM words through a 4-entry FIFO; build option SCAN_LOOP_EN
module fb_scan_reader #(
    parameter int RAM_WIDTH = 1,
    parameter int RAM_DEPTH = 10,
    localparam int AW = (RAM_DEPTH > 2) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        read_addr,
    output logic                 read_en,
    output logic                 output_en,
    output logic                 output_rst,
    input  logic [RAM_WIDTH-1:0] word_in,
    output logic [RAM_WIDTH-1:0] pix_data,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 pix_last
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

    state_t               state;
    logic [1:0]           vld_sr;
    logic [1:0]           last_sr;
    logic [RAM_WIDTH-1:0] fifo_data [4];
    logic [3:0]           fifo_last;
    logic [1:0]           wr_ptr;
    logic [1:0]           rd_ptr;
    logic [2:0]           count;
    logic [2:0]           outstanding;
    logic                 handshake;
    logic                 push;
    logic                 issue_last;

    // The stream is always the FIFO head; pix_last is masked so an empty FIFO never flags last.
    assign pix_valid   = (count != 3'd0);
    assign pix_data    = fifo_data[rd_ptr];
    assign pix_last    = fifo_last[rd_ptr] & pix_valid;
    assign handshake   = pix_valid & pix_ready;
    assign push        = vld_sr[1];
    // Reads in flight plus buffered words; a read may also be issued into the slot freed by a same-cycle pop.
    assign outstanding = count + {2'b00, vld_sr[0]} + {2'b00, vld_sr[1]};
    assign read_en     = (state == SCAN) && ((outstanding < 3'd4) || handshake);
    assign issue_last  = read_en && (read_addr == LAST_ADDR);

    // Two-stage valid/last pipeline mirroring the RAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr  <= 2'b00;
            last_sr <= 2'b00;
        end else begin
            vld_sr  <= {vld_sr[0], read_en};
            last_sr <= {last_sr[0], issue_last};
        end
    end

    // Capture FIFO: push when the pipeline delivers a word, pop on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) fifo_data[i] <= '0;
            fifo_last <= 4'b0000;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 3'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= word_in;
                fifo_last[wr_ptr] <= last_sr[1];
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (handshake) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count + 3'(push) - 3'(handshake);
        end
    end

    // Scan control FSM with registered status and RAM output-register controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            read_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            output_en  <= 1'b0;
            output_rst <= 1'b1;
        end else begin
            done <= handshake & pix_last;
            case (state)
                IDLE: begin
                    read_addr <= '0;
                    if (start) begin
                        state      <= SCAN;
                        busy       <= 1'b1;
                        output_en  <= 1'b1;
                        output_rst <= 1'b0;
                    end
                end
                SCAN: begin
                    if (read_en) begin
                        if (read_addr == LAST_ADDR) begin
`ifdef SCAN_LOOP_EN
                            read_addr <= '0;
`else
                            state <= DRAIN;
`endif
                        end else begin
                            read_addr <= read_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // The last word leaving the FIFO means nothing else is buffered or in flight.
                    if (handshake && pix_last) begin
                        state      <= IDLE;
                        read_addr  <= '0;
                        busy       <= 1'b0;
                        output_en  <= 1'b0;
                        output_rst <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_scan_reader.sv
// tb/tb_fb_scan_reader.sv - self-checking bench for fb_scan_reader with a 2-cycle RAM model
module tb_fb_scan_reader;
    localparam int W  = 8;
    localparam int D  = 10;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          pix_ready = 1'b0;
    logic          busy, done, read_en, output_en, output_rst, pix_valid, pix_last;
    logic [AW-1:0] read_addr;
    logic [W-1:0]  word_in, pix_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fb_scan_reader #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .read_addr(read_addr), .read_en(read_en), .output_en(output_en),
        .output_rst(output_rst), .word_in(word_in), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last)
    );

    // RAM: address registered on read_en, then an output register -> word valid two edges later.
    logic [W-1:0] mem [D];
    logic [W-1:0] ram_q;
    initial for (int i = 0; i < D; i++) mem[i] = 8'(16 + i);
    always @(posedge clk) begin
        if (read_en) ram_q <= (int'(read_addr) < D) ? mem[read_addr] : 8'hxx;
        if (output_rst) word_in <= '0;
        else if (output_en) word_in <= ram_q;
    end

    // Observation recorder (no checking): handshakes, reads, done pulses, stall stability.
    int          cyc = 0, hs_cnt = 0, rd_cnt = 0, done_cnt = 0, outst = 0, peak = 0, stall_err = 0;
    logic [W-1:0] got_data [1024];
    bit          got_last [1024];
    int          hs_cyc [1024];
    int          done_cyc [256];
    bit          done_busy [256];
    bit          prev_stall = 0;
    logic [W-1:0] prev_data;
    logic        prev_last;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            outst = 0; peak = 0; prev_stall = 0;
        end else begin
            if (prev_stall && (!pix_valid || pix_data !== prev_data || pix_last !== prev_last)) stall_err++;
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
            prev_last  = pix_last;
            if (pix_valid && pix_ready) begin
                got_data[hs_cnt & 1023] = pix_data;
                got_last[hs_cnt & 1023] = pix_last;
                hs_cyc[hs_cnt & 1023]   = cyc;
                hs_cnt++;
                outst--;
            end
            if (read_en) begin rd_cnt++; outst++; end
            if (outst > peak) peak = outst;
            if (done) begin
                done_cyc[done_cnt & 255]  = cyc;
                done_busy[done_cnt & 255] = busy;
                done_cnt++;
            end
        end
    end

    // Reference model: the k-th streamed word of any run of frames.
    function automatic logic [W-1:0] exp_word(input int k);
        return 8'(16 + (k % D));
    endfunction
    function automatic bit exp_last(input int k);
        return (k % D) == D - 1;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0 = done_cnt;
        ok = 0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (done_cnt > d0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        int r0;
        rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
        tick(); tick();
        total++;
        if ({busy, done, read_en, output_en, output_rst, pix_valid, pix_last} !== 7'b0000100) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0000100", {busy, done, read_en, output_en, output_rst, pix_valid, pix_last});
        end
        total++;
        if (pix_data !== 8'h00 || read_addr !== 4'd0) begin
            bad++; $display("FAIL reset_data got data=%h addr=%0d want 00/0", pix_data, read_addr);
        end
        rst = 1'b0;
        r0 = rd_cnt;
        repeat (5) tick();
        total++;
        if (rd_cnt != r0 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_quiet got reads=%0d busy=%b want 0/0", rd_cnt - r0, busy);
        end
    endtask

    task automatic test_stream();
        int b, d0, n; bit ok;
        do_reset();
        pix_ready = 1'b1; b = hs_cnt; d0 = done_cnt;
        pulse_start();
        n = 0;
        while (!pix_valid && n < 20) begin tick(); n++; end
        total++;
        if (n != 3) begin bad++; $display("FAIL first_valid got=%0d cycles want=3", n); end
        wait_done(40, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stream_done got=timeout want=done"); end
        tick();
        total++;
        if (hs_cnt - b != D || done_cnt - d0 != 1) begin
            bad++; $display("FAIL stream_count got words=%0d dones=%0d want %0d/1", hs_cnt - b, done_cnt - d0, D);
        end
        for (int i = 0; i < D; i++) begin
            total++;
            if (got_data[b + i] !== exp_word(i) || got_last[b + i] !== exp_last(i) || hs_cyc[b + i] != hs_cyc[b] + i) begin
                bad++; $display("FAIL stream_word[%0d] got=%h last=%b cyc=%0d want=%h last=%b cyc=%0d", i,
                    got_data[b + i], got_last[b + i], hs_cyc[b + i] - hs_cyc[b], exp_word(i), exp_last(i), i);
            end
        end
        total++;
        if (done_cyc[d0 & 255] != hs_cyc[b + D - 1] + 1 || done_busy[d0 & 255] !== 1'b0) begin
            bad++; $display("FAIL stream_done_time got=+%0d busy=%b want=+1 busy=0",
                done_cyc[d0 & 255] - hs_cyc[b + D - 1], done_busy[d0 & 255]);
        end
    endtask

    task automatic test_backpressure();
        int b, r0, s0; bit ok; bit hold_ok;
        do_reset();
        pix_ready = 1'b0; b = hs_cnt; r0 = rd_cnt; s0 = stall_err;
        pulse_start();
        hold_ok = 1;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (n >= 3 && (pix_valid !== 1'b1 || pix_data !== 8'h10)) hold_ok = 0;
        end
        total++;
        if (rd_cnt - r0 != 4 || read_en !== 1'b0) begin
            bad++; $display("FAIL bp_reads got=%0d read_en=%b want=4/0", rd_cnt - r0, read_en);
        end
        total++;
        if (!hold_ok) begin bad++; $display("FAIL bp_hold got valid=%b data=%h want 1/10", pix_valid, pix_data); end
        pix_ready = 1'b1;
        wait_done(60, ok);
        total++;
        if (!ok || hs_cnt - b != D || stall_err != s0) begin
            bad++; $display("FAIL bp_complete got done=%b words=%0d stall_err=%0d want 1/%0d/0", ok, hs_cnt - b, stall_err - s0, D);
        end
        for (int i = 0; i < D; i++) begin
            total++;
            if (got_data[b + i] !== exp_word(i) || got_last[b + i] !== exp_last(i)) begin
                bad++; $display("FAIL bp_word[%0d] got=%h/%b want=%h/%b", i, got_data[b + i], got_last[b + i], exp_word(i), exp_last(i));
            end
        end
    endtask

    // mode 0: ready toggles each cycle; mode 1: random ready, several frames back to back.
    task automatic test_flow(input int mode, input int frames);
        int b, s0, d0; bit ok;
        do_reset();
        b = hs_cnt; s0 = stall_err; d0 = done_cnt;
        for (int f = 0; f < frames; f++) begin
            pix_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            pulse_start();
            ok = 0;
            for (int n = 0; n < 200; n++) begin
                pix_ready = (mode == 0) ? ~pix_ready : 1'($urandom_range(0, 3) != 0);
                tick();
                if (done_cnt - d0 > f) begin ok = 1; break; end
            end
            total++;
            if (!ok) begin bad++; $display("FAIL flow%0d_done[%0d] got=timeout want=done", mode, f); end
        end
        tick();
        total++;
        if (hs_cnt - b != D * frames || done_cnt - d0 != frames) begin
            bad++; $display("FAIL flow%0d_count got words=%0d dones=%0d want %0d/%0d", mode, hs_cnt - b, done_cnt - d0, D * frames, frames);
        end
        for (int i = 0; i < D * frames; i++) begin
            total++;
            if (got_data[b + i] !== exp_word(i) || got_last[b + i] !== exp_last(i)) begin
                bad++; $display("FAIL flow%0d_word[%0d] got=%h/%b want=%h/%b", mode, i, got_data[b + i], got_last[b + i], exp_word(i), exp_last(i));
            end
        end
        total++;
        if (peak > 4 || stall_err != s0) begin
            bad++; $display("FAIL flow%0d_limits got peak=%0d stall_err=%0d want <=4/0", mode, peak, stall_err - s0);
        end
    endtask

    task automatic test_restart();
        int b, r0, d0; bit ok;
        do_reset();
        pix_ready = 1'b1; b = hs_cnt; r0 = rd_cnt; d0 = done_cnt;
        pulse_start();
        tick(); tick();
        pulse_start();
        repeat (7) tick();
        pulse_start();
        wait_done(40, ok);
        repeat (15) tick();
        total++;
        if (!ok || rd_cnt - r0 != D || hs_cnt - b != D || done_cnt - d0 != 1 || busy !== 1'b0) begin
            bad++; $display("FAIL restart got reads=%0d words=%0d dones=%0d busy=%b want %0d/%0d/1/0",
                rd_cnt - r0, hs_cnt - b, done_cnt - d0, busy, D, D);
        end
        for (int i = 0; i < D; i++) begin
            total++;
            if (got_data[b + i] !== exp_word(i)) begin
                bad++; $display("FAIL restart_word[%0d] got=%h want=%h", i, got_data[b + i], exp_word(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int b, n; bit ok;
        do_reset();
        pix_ready = 1'b1; b = hs_cnt;
        pulse_start();
        n = 0;
        while (hs_cnt - b < 5 && n < 30) begin tick(); n++; end
        total++;
        if (hs_cnt - b < 5) begin bad++; $display("FAIL mid_reach got=%0d words want=5", hs_cnt - b); end
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, read_en, output_en, output_rst, pix_valid, pix_last} !== 7'b0000100 || pix_data !== 8'h00 || read_addr !== 4'd0) begin
            bad++; $display("FAIL mid_reset got ctrl=%b data=%h addr=%0d want 0000100/00/0",
                {busy, done, read_en, output_en, output_rst, pix_valid, pix_last}, pix_data, read_addr);
        end
        tick(); tick();
        rst = 1'b0;
        b = hs_cnt;
        repeat (6) tick();
        total++;
        if (hs_cnt != b || pix_valid !== 1'b0) begin
            bad++; $display("FAIL mid_leak got words=%0d valid=%b want 0/0", hs_cnt - b, pix_valid);
        end
        pulse_start();
        wait_done(40, ok);
        total++;
        if (!ok || hs_cnt - b != D) begin bad++; $display("FAIL mid_restart got done=%b words=%0d want 1/%0d", ok, hs_cnt - b, D); end
        for (int i = 0; i < D; i++) begin
            total++;
            if (got_data[b + i] !== exp_word(i) || got_last[b + i] !== exp_last(i)) begin
                bad++; $display("FAIL mid_word[%0d] got=%h/%b want=%h/%b", i, got_data[b + i], got_last[b + i], exp_word(i), exp_last(i));
            end
        end
    endtask

    task automatic test_loop();
        int b, d0; bit busy_ok;
        do_reset();
        pix_ready = 1'b1; b = hs_cnt; d0 = done_cnt;
        pulse_start();
        busy_ok = 1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (busy !== 1'b1) busy_ok = 0;
        end
        total++;
        if (!busy_ok || hs_cnt - b < 30 || done_cnt - d0 < 3) begin
            bad++; $display("FAIL loop_run got busy_ok=%b words=%0d dones=%0d want 1/>=30/>=3", busy_ok, hs_cnt - b, done_cnt - d0);
        end
        for (int i = 0; i < 30; i++) begin
            total++;
            if (got_data[b + i] !== exp_word(i) || got_last[b + i] !== exp_last(i) || hs_cyc[b + i] != hs_cyc[b] + i) begin
                bad++; $display("FAIL loop_word[%0d] got=%h/%b cyc=+%0d want=%h/%b cyc=+%0d", i,
                    got_data[b + i], got_last[b + i], hs_cyc[b + i] - hs_cyc[b], exp_word(i), exp_last(i), i);
            end
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (done_cyc[(d0 + k) & 255] != hs_cyc[b + D * k + D - 1] + 1 || done_busy[(d0 + k) & 255] !== 1'b1) begin
                bad++; $display("FAIL loop_done[%0d] got=+%0d busy=%b want=+1 busy=1", k,
                    done_cyc[(d0 + k) & 255] - hs_cyc[b + D * k + D - 1], done_busy[(d0 + k) & 255]);
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef SCAN_LOOP_EN
        test_loop();
`else
        test_stream();
        test_backpressure();
        test_flow(0, 1);
        test_flow(1, 3);
        test_restart();
        test_reset_mid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fb_scan_reader.md
FB_SCAN_READER -- requirements
Module: fb_scan_reader

Interface
REQ-001 The block SHALL have parameter RAM_WIDTH, default 1: width in bits of one stored word.
REQ-002 The block SHALL have parameter RAM_DEPTH, default 10: words per frame. AW = clogb2(RAM_DEPTH-1).
REQ-003 The block SHALL have port clk  in  1: single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-005 The block SHALL have port start  in  1: single-cycle request to begin a scan at address 0.
REQ-006 The block SHALL have port busy  out  1: high from the cycle after start is accepted until the scan completes.
REQ-007 The block SHALL have port done  out  1: one-cycle pulse on scan completion.
REQ-008 The block SHALL have port read_addr  out  AW: RAM read address.
REQ-009 The block SHALL have port read_en  out  1: RAM read enable; one read is issued per cycle in which it is high.
REQ-010 The block SHALL have port output_en  out  1: RAM output register enable.
REQ-011 The block SHALL have port output_rst  out  1: RAM output register reset.
REQ-012 The block SHALL have port word_in  in  RAM_WIDTH: RAM output data.
REQ-013 The block SHALL have port pix_data  out  RAM_WIDTH: stream data.
REQ-014 The block SHALL have port pix_valid  out  1: stream data valid.
REQ-015 The block SHALL have port pix_ready  in  1: stream sink ready.
REQ-016 The block SHALL have port pix_last  out  1: qualifies the word read from address RAM_DEPTH-1.

Function
REQ-017 The state machine SHALL have states IDLE, SCAN and DRAIN: IDLE->SCAN on start; SCAN->DRAIN after address RAM_DEPTH-1 is issued; DRAIN->IDLE when the FIFO is empty and nothing is in flight.
REQ-018 In IDLE, start SHALL be accepted; in SCAN and DRAIN, start SHALL be ignored.
REQ-019 Read latency SHALL be 2: word_in is captured at the second rising edge after the edge that samples read_en=1.
REQ-020 Capture timing SHALL be tracked by a 2-stage valid/last shift register, not by a counter.
REQ-021 output_en SHALL be 1 and output_rst SHALL be 0 in SCAN and DRAIN; output_en SHALL be 0 and output_rst SHALL be 1 in IDLE.
REQ-022 Captured words SHALL enter a 4-entry FIFO in issue order; pix_data, pix_valid and pix_last SHALL be driven from the FIFO head.
REQ-023 A handshake SHALL occur when pix_valid=1 and pix_ready=1; the FIFO SHALL pop on that edge.
REQ-024 Outstanding SHALL count reads in flight plus FIFO occupancy, range 0..4.
REQ-025 In SCAN, read_en SHALL be 1 only when outstanding<4 or a handshake occurs in the same cycle, so the FIFO never overflows and no word is lost.
REQ-026 read_addr SHALL increment by 1 after each issued read and return to 0 in IDLE.
REQ-027 With pix_ready held at 1, throughput SHALL be 1 word per cycle and the first pix_valid SHALL be high 3 cycles after the edge that samples start.
REQ-028 pix_data and pix_last SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-029 done SHALL pulse, and busy SHALL fall, in the cycle after the handshake of the pix_last word.
REQ-030 A FIFO push and pop on the same edge SHALL leave occupancy unchanged.

Reset
REQ-031 While rst=1 the block SHALL be in IDLE with read_addr=0, read_en=0, output_en=0, output_rst=1, pix_valid=0, pix_last=0, pix_data=0, busy=0, done=0, FIFO empty and in-flight bits cleared.
REQ-032 Reset asserted mid-scan SHALL discard all in-flight and buffered words; no partial-frame word SHALL appear after release.

Configuration
REQ-033 Macro SCAN_LOOP_EN SHALL be the only build option.
REQ-034 With SCAN_LOOP_EN defined: after address RAM_DEPTH-1 is issued, read_addr wraps to 0 and issue continues with no bubble; done pulses after each pix_last handshake; busy stays 1 and DRAIN is never entered; only rst returns the block to IDLE.
REQ-035 With SCAN_LOOP_EN undefined: one frame per start, as REQ-017 to REQ-029.

Verification (RAM_WIDTH=8, RAM_DEPTH=10, RAM model with mem[i]=0x10+i)
REQ-036 The bench SHALL check: start, pix_ready=1 -> pix_valid rises 3 cycles later; data 0x10..0x19 on consecutive cycles; pix_last only with 0x19; done is 1 cycle after that handshake.
REQ-037 The bench SHALL check: pix_ready=0 for 8 cycles after start -> read_en stops after 4 reads; pix_valid=1 holding 0x10; on ready=1 the sequence completes in order with no drop or duplicate.
REQ-038 The bench SHALL check: pix_ready toggling 1/0 each cycle -> all 10 words arrive in order; outstanding never exceeds 4.
REQ-039 The bench SHALL check: start re-pulsed in SCAN and in DRAIN -> ignored; exactly 10 words and one done.
REQ-040 The bench SHALL check: rst asserted after the 5th handshake -> all outputs at reset values immediately; a new start gives 0x10..0x19 cleanly.
REQ-041 The bench SHALL check (SCAN_LOOP_EN): pix_ready=1 for 30 cycles -> 0x10..0x19 repeated with no gap; done pulses every 10 handshakes; busy stays 1.
